mem_stage_mc: RTL and testbench

MEM_STAGE_MC -- requirements
Module: mem_stage_mc

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/imm_fwd.sv | 24 ++
 rtl/mem_stage_mc.sv | 111 +++++++++++
 tb/tb_mem_stage_mc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage multi-cycle memory interface:
// FSM state encoding and default parameter values.
package mem_stage_pkg;

  localparam int DEF_DW      = 16;
  localparam int DEF_AW      = 16;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/imm_fwd.sv
// Immediate forwarding merge: replaces one half of the MEM immediate
// with the matching half of the WB immediate.
module imm_fwd #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] imm_mem,
  input  logic [DW-1:0] imm_wb,
  input  logic          fwd,
  input  logic          ld_byte,
  output logic [DW-1:0] imm_out
);

  localparam int H = DW / 2;

  // ld_byte=1 is the low-half load, so the upper half comes from WB.
  always_comb begin
    imm_out = imm_mem;
    if (fwd) begin
      if (ld_byte) imm_out = {imm_wb[DW-1:H], imm_mem[H-1:0]};
      else         imm_out = {imm_mem[DW-1:H], imm_wb[H-1:0]};
    end
  end

endmodule

// File: rtl/mem_stage_mc.sv
// MEM pipeline stage with a multi-cycle data-memory handshake, a WAIT
// timeout abort, pipeline stall generation and immediate forwarding.
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] RegData2,
  input  logic          MemOp,
  input  logic          MemWrite,
  input  logic          ForwardImm,
  input  logic          LdByte,
  input  logic [DW-1:0] imm_MEM,
  input  logic [DW-1:0] imm_WB,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_out,
  output logic [DW-1:0] imm_out,
  output logic          stall,
  output logic          mem_err,
  output state_t        state_dbg
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          timed_out;

  assign state_dbg = state_q;

  // Handshake: mem_req stays high with mem_addr/mem_wdata/mem_wr stable
  // until a cycle where mem_gnt=1; the access then completes on the first
  // WAIT cycle with mem_valid=1. gnt/valid in any other state are ignored.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemOp) begin
          stall   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        // valid on the final allowed WAIT cycle still completes normally
        if (mem_valid) begin
          state_d = S_DONE;
        end else if (cnt_q == LAST) begin
          state_d   = S_DONE;
          timed_out = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_out   <= '0;
      mem_err   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      mem_err <= timed_out;
      if (state_q == S_IDLE && MemOp) begin
        mem_addr  <= alu_out;
        mem_wdata <= RegData2;
        mem_wr    <= MemWrite;
      end
      // Held at zero outside WAIT, so every WAIT entry starts from 0.
      if (state_q == S_WAIT) cnt_q <= cnt_q + CW'(1);
      else                   cnt_q <= '0;
      if (state_q == S_WAIT && mem_valid && !mem_wr) mem_out <= mem_rdata;
      else if (timed_out)                            mem_out <= '0;
    end
  end

  imm_fwd #(.DW(DW)) u_imm_fwd (
    .imm_mem (imm_MEM),
    .imm_wb  (imm_WB),
    .fwd     (ForwardImm),
    .ld_byte (LdByte),
    .imm_out (imm_out)
  );

endmodule

// File: tb/tb_mem_stage_mc.sv
// Self-checking bench for mem_stage_mc: immediate-merge vector table,
// directed access sequences and randomized accesses against a reference model.
module tb_mem_stage_mc;
  import mem_stage_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int T  = 4;
  localparam logic [DW-1:0] HI_MASK = {{(DW/2){1'b1}}, {(DW/2){1'b0}}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] alu_out;
  logic [DW-1:0] RegData2, imm_MEM, imm_WB, mem_rdata;
  logic          MemOp, MemWrite, ForwardImm, LdByte, mem_gnt, mem_valid;
  logic          mem_req, mem_wr, stall, mem_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_out, imm_out;
  state_t        state_dbg;

  mem_stage_mc #(.DW(DW), .AW(AW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .RegData2(RegData2),
    .MemOp(MemOp), .MemWrite(MemWrite), .ForwardImm(ForwardImm),
    .LdByte(LdByte), .imm_MEM(imm_MEM), .imm_WB(imm_WB),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .mem_out(mem_out), .imm_out(imm_out),
    .stall(stall), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference merge from the half-word rule, written with masks.
  function automatic logic [DW-1:0] imm_ref(input logic [DW-1:0] im, input logic [DW-1:0] iw,
                                            input logic f, input logic lb);
    if (!f) return im;
    if (lb) return (iw & HI_MASK) | (im & ~HI_MASK);
    return (im & HI_MASK) | (iw & ~HI_MASK);
  endfunction

  typedef struct {
    logic [DW-1:0] im;
    logic [DW-1:0] iw;
    logic          f;
    logic          lb;
    logic [DW-1:0] exp;
  } imm_vec_t;

  imm_vec_t imm_tab[6];

  // ---------------- driver: one full memory access ----------------
  // g = REQ cycles before gnt, v = WAIT cycles before valid (v >= T -> never).
  task automatic run_access(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                            input int g, input int v, input logic keep_op);
    int req_n, wait_n, stalls, exp_stalls;
    logic granted, done, to;
    logic [DW-1:0] exp_out;
    to         = (v >= T);
    exp_stalls = 2 + g + (to ? T : v + 1);
    exp_out    = to ? '0 : (wr ? model_out : rdata);
    exp_q.push_back(exp_out);
    req_n = 0; wait_n = 0; stalls = 0; granted = 0; done = 0;
    @(negedge clk);
    MemOp = 1'b1; MemWrite = wr; alu_out = addr; RegData2 = wdata;
    mem_gnt = 1'b0; mem_valid = 1'b0;
    #1;
    chk("idle_entry_state", 32'(state_dbg), 32'(S_IDLE));
    chk("idle_entry_req", 32'(mem_req), 32'd0);
    chk("err_pulse_end", 32'(mem_err), 32'd0);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (!stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (mem_req) begin
          chk("req_addr", 32'(mem_addr), 32'(addr));
          chk("req_wdata", 32'(mem_wdata), 32'(wdata));
          chk("req_wr", 32'(mem_wr), 32'(wr));
          mem_gnt = (req_n == g);
          if (mem_gnt) granted = 1'b1;
          mem_rdata = DW'($urandom);
          req_n++;
        end else if (granted) begin
          mem_valid = (wait_n == v);
          mem_rdata = mem_valid ? rdata : DW'($urandom);
          wait_n++;
        end
        @(negedge clk);
        mem_gnt = 1'b0; mem_valid = 1'b0;
        #1;
      end
    end
    chk("access_end", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("done_state", 32'(state_dbg), 32'(S_DONE));
    chk("mem_out", 32'(mem_out), 32'(exp_q.pop_front()));
    chk("mem_err", 32'(mem_err), 32'(to));
    MemOp = keep_op;
    #1;
    chk("done_no_req", 32'(mem_req), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
    model_out = exp_out;
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; MemOp = 0; MemWrite = 0; ForwardImm = 0; LdByte = 0;
    alu_out = '0; RegData2 = '0; imm_MEM = '0; imm_WB = '0;
    mem_gnt = 0; mem_valid = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_out", 32'(mem_out), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    imm_tab[0] = '{16'hAABB, 16'hCCDD, 1'b1, 1'b1, 16'hCCBB};
    imm_tab[1] = '{16'hAABB, 16'hCCDD, 1'b1, 1'b0, 16'hAADD};
    imm_tab[2] = '{16'hAABB, 16'hCCDD, 1'b0, 1'b1, 16'hAABB};
    imm_tab[3] = '{16'hAABB, 16'hCCDD, 1'b0, 1'b0, 16'hAABB};
    imm_tab[4] = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hFF00};
    imm_tab[5] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h00FF};
    foreach (imm_tab[i]) begin
      imm_MEM = imm_tab[i].im; imm_WB = imm_tab[i].iw;
      ForwardImm = imm_tab[i].f; LdByte = imm_tab[i].lb;
      #1;
      chk("imm_table", 32'(imm_out), 32'(imm_tab[i].exp));
    end
    for (int i = 0; i < 20; i++) begin
      imm_MEM = DW'($urandom); imm_WB = DW'($urandom);
      ForwardImm = 1'($urandom_range(0, 1)); LdByte = 1'($urandom_range(0, 1));
      #1;
      chk("imm_rand", 32'(imm_out), 32'(imm_ref(imm_MEM, imm_WB, ForwardImm, LdByte)));
    end

    model_out = '0;
    run_access(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 1, 1'b0);   // load, 4 stalls
    run_access(1'b1, 16'h0010, 16'h1234, 16'h5A5A, 2, 0, 1'b0);   // store, gnt late
    run_access(1'b0, 16'h0020, 16'h0000, 16'h7777, 0, 99, 1'b0);  // timeout
    run_access(1'b0, 16'h0022, 16'h0000, 16'h4242, 1, T - 1, 1'b0); // valid on last cycle
    run_access(1'b1, 16'h0024, 16'h9999, 16'h0000, 0, 99, 1'b0);  // store timeout
    run_access(1'b0, 16'h0100, 16'h0000, 16'h1111, 0, 0, 1'b1);   // back-to-back
    run_access(1'b0, 16'h0102, 16'h0000, 16'h2222, 0, 0, 1'b0);

    // stray gnt/valid while idle must be ignored
    @(negedge clk);
    MemOp = 1'b0; mem_gnt = 1'b1; mem_valid = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_gnt = 1'b0; mem_valid = 1'b0;
    #1;
    chk("stray_state", 32'(state_dbg), 32'(S_IDLE));
    chk("stray_out", 32'(mem_out), 32'(model_out));

    // reset during WAIT, late valid afterwards
    @(negedge clk); MemOp = 1'b1; MemWrite = 1'b0; alu_out = 16'h0300;
    @(negedge clk); MemOp = 1'b0; mem_gnt = 1'b1;
    #1; chk("rw_in_req", 32'(state_dbg), 32'(S_REQ));
    @(negedge clk); mem_gnt = 1'b0; rst = 1'b1;
    #1; chk("rw_in_wait", 32'(state_dbg), 32'(S_WAIT));
    @(negedge clk); rst = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5555;
    #1;
    chk("rw_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rw_out", 32'(mem_out), 32'd0);
    chk("rw_addr", 32'(mem_addr), 32'd0);
    @(negedge clk); mem_valid = 1'b0;
    #1;
    chk("rw_no_capture", 32'(mem_out), 32'd0);
    chk("rw_no_retry", 32'(mem_req), 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    model_out = '0;

    for (int i = 0; i < 30; i++) begin
      run_access(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), DW'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, T + 1)),
                 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
